pps_timebase_gen: RTL

Parametrised timebase generator that sits directly behind the PPS-domain PLL output and turns that clock into a disciplined one-pulse-per-second strobe plus N programmable divided tick/clock channels. It gates all outputs on PLL lock with a settle interval and measures the cycle count between external PPS edges for software readout. Channels are phase-realigned on every local second boundary.

---
 rtl/pps_pkg.sv | 15 +
 rtl/pps_div_channel.sv | 53 +++++
 rtl/pps_timebase_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pps_pkg.sv
// Shared types and helpers for the PPS timebase generator.
package pps_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } pps_state_e;

  // Default channel divisor: a 1 kHz tick from the nominal clock.
  function automatic int div_reset_val(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/pps_div_channel.sv
// One programmable divided channel: divisor register, wrap counter,
// one-cycle tick on wrap and a square wave toggling on each tick.
module pps_div_channel
  import pps_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CLK_HZ = 120000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,    // outside RUN or second boundary
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_tick,
  output logic             o_clk
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(div_reset_val(CLK_HZ));

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk;
  logic             w_en;
  logic             w_wrap;

  // Divisors below 2 make no sense as a period, so they park the channel.
  assign w_en   = (r_div >= CNT_W'(2));
  assign w_wrap = w_en && (r_cnt == r_div - CNT_W'(1));

  // Divisor register survives leaving RUN; only reset restores the default.
  always_ff @(posedge i_clk) begin
    if (i_reset)   r_div <= RST_DIV;
    else if (i_we) r_div <= i_val;
  end

  // Wrap counter; a wrap on the write cycle still ticks, then restarts under the new divisor.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr || !w_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap) r_clk <= ~r_clk;
      r_cnt <= (w_wrap || i_we) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = r_tick;
  assign o_clk  = r_clk;

endmodule

// File: rtl/pps_timebase_gen.sv
// Disciplined 1PPS timebase: lock/settle gating, local second counter
// realigned by external PPS, divided channels and PPS interval measurement.
module pps_timebase_gen
  import pps_pkg::*;
#(
  parameter int CLK_HZ      = 120000000,
  parameter int CNT_W       = 32,
  parameter int N_CH        = 4,
  parameter int SETTLE_CYC  = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int DISCIPLINE  = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_pll_lock,
  input  logic                                  i_pps_in,
  input  logic                                  i_div_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_div_sel,
  input  logic [CNT_W-1:0]                      i_div_val,
  output logic                                  o_locked,
  output logic                                  o_pps_out,
  output logic [N_CH-1:0]                       o_ch_tick,
  output logic [N_CH-1:0]                       o_ch_clk,
  output logic [CNT_W-1:0]                      o_meas_cycles,
  output logic                                  o_meas_valid,
  output logic                                  o_meas_timeout
);

  localparam int               ST_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] TO_CYC   = CNT_W'(2 * CLK_HZ);
  localparam bit               DISC     = (DISCIPLINE != 0);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_pps_sync;
  logic                   r_pps_prev;
  logic                   r_edge;
  logic                   w_lock;
  logic                   w_pps_s;

  pps_state_e             r_state;
  pps_state_e             w_state_nxt;
  logic [ST_W-1:0]        r_settle_cnt;

  logic [CNT_W-1:0]       r_sec;
  logic                   r_pps;
  logic                   r_locked;
  logic [CNT_W-1:0]       r_mcnt;
  logic [CNT_W-1:0]       r_meas;
  logic                   r_armed;
  logic                   r_mvalid;
  logic                   r_timeout;

  logic                   w_run_nxt;
  logic                   w_enter;
  logic                   w_stay;
  logic                   w_pps_nxt;
  logic                   w_ch_clr;
  logic [CNT_W-1:0]       w_mcnt_inc;
  logic [N_CH-1:0]        w_ch_we;

  assign w_lock  = r_lock_sync[SYNC_STAGES-1];
  assign w_pps_s = r_pps_sync[SYNC_STAGES-1];

  // Synchronisers for the asynchronous inputs, plus a registered rising-edge flag for PPS.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lock_sync <= '0;
      r_pps_sync  <= '0;
      r_pps_prev  <= 1'b0;
      r_edge      <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_pll_lock};
      r_pps_sync  <= {r_pps_sync[SYNC_STAGES-2:0], i_pps_in};
      r_pps_prev  <= w_pps_s;
      r_edge      <= w_pps_s && !r_pps_prev;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= WAIT_LOCK;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: lock must hold through the whole settle window.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOCK: if (w_lock) w_state_nxt = SETTLE;
      SETTLE: begin
        if (!w_lock)                     w_state_nxt = WAIT_LOCK;
        else if (r_settle_cnt == ST_LAST) w_state_nxt = RUN;
      end
      RUN:       if (!w_lock) w_state_nxt = WAIT_LOCK;
      default:   w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Settle counter runs only while in SETTLE.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != SETTLE) r_settle_cnt <= '0;
    else                              r_settle_cnt <= r_settle_cnt + ST_W'(1);
  end

  // Outputs are computed from the next state so they drop on the same edge RUN is left.
  assign w_run_nxt  = (w_state_nxt == RUN);
  assign w_enter    = (r_state != RUN) && w_run_nxt;
  assign w_stay     = (r_state == RUN) && w_run_nxt;
  assign w_pps_nxt  = w_enter || (w_stay && ((DISC && r_edge) || (r_sec == SEC_LAST)));
  assign w_ch_clr   = w_pps_nxt || !w_run_nxt;
  assign w_mcnt_inc = (&r_mcnt) ? r_mcnt : r_mcnt + CNT_W'(1);

  // Lock indicator.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_locked <= 1'b0;
    else         r_locked <= w_run_nxt;
  end

  // Local second counter, PPS strobe and edge-to-edge interval measurement.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sec     <= '0;
      r_pps     <= 1'b0;
      r_mcnt    <= '0;
      r_meas    <= '0;
      r_armed   <= 1'b0;
      r_mvalid  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (!w_stay) begin
      r_sec     <= '0;
      r_pps     <= w_enter;
      r_mcnt    <= '0;
      r_armed   <= 1'b0;
      r_mvalid  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pps    <= w_pps_nxt;
      r_sec    <= w_pps_nxt ? '0 : r_sec + CNT_W'(1);
      r_mvalid <= r_edge && r_armed;
      if (r_edge) begin
        // first edge after RUN entry only arms the measurement
        if (r_armed) r_meas <= w_mcnt_inc;
        r_mcnt    <= '0;
        r_armed   <= 1'b1;
        r_timeout <= 1'b0;
      end else begin
        r_mcnt <= w_mcnt_inc;
        if (w_mcnt_inc >= TO_CYC) r_timeout <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    // out-of-range selects match no channel and are dropped
    assign w_ch_we[k] = i_div_we && (32'(i_div_sel) == k);

    pps_div_channel #(
      .CNT_W  (CNT_W),
      .CLK_HZ (CLK_HZ)
    ) u_ch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_ch_clr),
      .i_we    (w_ch_we[k]),
      .i_val   (i_div_val),
      .o_tick  (o_ch_tick[k]),
      .o_clk   (o_ch_clk[k])
    );
  end

  assign o_locked       = r_locked;
  assign o_pps_out      = r_pps;
  assign o_meas_cycles  = r_meas;
  assign o_meas_valid   = r_mvalid;
  assign o_meas_timeout = r_timeout;

endmodule
